// File: rtl/dump_sequencer.sv
// Debug-dump engine: serialises register bank, PC and an END marker into UART frames.
// Define DUMP_DELTA_EN to build the shadow bank that enables changed-only dumps.
module dump_sequencer #(
    parameter int UART_BUS_SIZE = 8,
    parameter int NUM_REGS      = 32,
    parameter int REG_WIDTH     = 32,
    parameter int FRAME_SIZE    = 3*UART_BUS_SIZE + REG_WIDTH
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_is_mem,
    input  logic                          i_delta,
    input  logic [NUM_REGS*REG_WIDTH-1:0] i_reg_bank,
    input  logic [UART_BUS_SIZE-1:0]      i_clk_cycle,
    input  logic [REG_WIDTH-1:0]          i_current_pc,
    input  logic                          i_write_finish,
    output logic                          o_write,
    output logic [FRAME_SIZE-1:0]         o_data_write,
    output logic                          o_busy,
    output logic                          o_finish
);
    localparam int PW = $clog2(NUM_REGS) + 1;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PW-1:0] PTR_PC  = PW'(NUM_REGS);
    localparam logic [PW-1:0] PTR_END = PW'(NUM_REGS + 1);
    localparam logic [UART_BUS_SIZE-1:0] T_REG = UART_BUS_SIZE'(1);
    localparam logic [UART_BUS_SIZE-1:0] T_MEM = UART_BUS_SIZE'(2);
    localparam logic [UART_BUS_SIZE-1:0] T_PC  = UART_BUS_SIZE'(3);
    localparam logic [UART_BUS_SIZE-1:0] T_END = UART_BUS_SIZE'(4);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT} state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [REG_WIDTH-1:0]    cnt_q, cnt_d;
    logic [FRAME_SIZE-1:0]   data_q, data_d;
    logic                    write_q, write_d;
    logic [REG_WIDTH-1:0]    bank_a [NUM_REGS];
    logic [IW-1:0]           reg_idx;
    logic [REG_WIDTH-1:0]    cur_reg;
    logic [UART_BUS_SIZE-1:0] reg_type;
    logic                    skip;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            bank_a[k] = i_reg_bank[k*REG_WIDTH +: REG_WIDTH];
        end
    end

    // Index is clamped so the bank read stays in range during PC/END frames.
    assign reg_idx  = (ptr_q < PTR_PC) ? ptr_q[IW-1:0] : '0;
    assign cur_reg  = bank_a[reg_idx];
    assign reg_type = i_is_mem ? T_MEM : T_REG;

`ifdef DUMP_DELTA_EN
    logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
    logic                 delta_q, delta_d;
    logic                 shadow_we;

    assign delta_d   = (state_q == S_IDLE && i_start) ? i_delta : delta_q;
    assign skip      = delta_q && (cur_reg == shadow_q[reg_idx]);
    assign shadow_we = (state_q == S_SCAN) && (ptr_q < PTR_PC) && !skip && !i_abort;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            delta_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            delta_q <= delta_d;
            if (shadow_we) begin
                shadow_q[reg_idx] <= cur_reg;
            end
        end
    end
`else
    logic unused_delta;
    assign unused_delta = i_delta;
    assign skip         = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        write_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_SCAN;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_SCAN: begin
                if (ptr_q < PTR_PC) begin
                    ptr_d = ptr_q + PW'(1);
                    if (!skip) begin
                        data_d  = FRAME_SIZE'({reg_type, i_clk_cycle, UART_BUS_SIZE'(ptr_q), cur_reg});
                        cnt_d   = cnt_q + REG_WIDTH'(1);
                        write_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (ptr_q == PTR_PC) begin
                    data_d  = FRAME_SIZE'({T_PC, i_clk_cycle, {UART_BUS_SIZE{1'b0}}, i_current_pc});
                    ptr_d   = ptr_q + PW'(1);
                    write_d = 1'b1;
                    state_d = S_WAIT;
                end else if (ptr_q == PTR_END) begin
                    data_d  = FRAME_SIZE'({T_END, i_clk_cycle, {UART_BUS_SIZE{1'b0}}, cnt_q});
                    ptr_d   = ptr_q + PW'(1);
                    write_d = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (i_write_finish) begin
                    state_d = S_SCAN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle write_finish.
        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            ptr_d   = '0;
            cnt_d   = cnt_q;
            data_d  = data_q;
            write_d = 1'b0;
        end
    end

    always_comb begin
        o_busy   = (state_q != S_IDLE);
        o_finish = (state_q == S_SCAN) && (ptr_q > PTR_END) && !i_abort;
    end

    assign o_write      = write_q;
    assign o_data_write = data_q;

endmodule

// File: tb/tb_dump_sequencer.sv
// Randomised bench for dump_sequencer with a frame-list reference model and scoreboard.
// Honours DUMP_DELTA_EN the same way as the design build.
module tb_dump_sequencer;
    localparam int UB = 8;
    localparam int NR = 32;
    localparam int RW = 32;
    localparam int FS = 3*UB + RW;
`ifdef DUMP_DELTA_EN
    localparam bit DELTA_EN = 1'b1;
`else
    localparam bit DELTA_EN = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset_n = 1'b0;
    logic             i_start = 1'b0;
    logic             i_abort = 1'b0;
    logic             i_is_mem = 1'b0;
    logic             i_delta = 1'b0;
    logic [NR*RW-1:0] i_reg_bank;
    logic [UB-1:0]    i_clk_cycle = '0;
    logic [RW-1:0]    i_current_pc = '0;
    logic             i_write_finish = 1'b0;
    logic             o_write;
    logic [FS-1:0]    o_data_write;
    logic             o_busy;
    logic             o_finish;

    logic [RW-1:0]    bank [NR];
    logic [RW-1:0]    m_shadow [NR];
    logic [FS-1:0]    exp_q [$];
    logic [FS-1:0]    obs_q [$];
    logic [FS-1:0]    last_frame;
    logic             have_frame = 1'b0;
    logic             prev_write = 1'b0;
    int               total = 0;
    int               bad = 0;
    int               fin_cnt = 0;
    int               last_lat = 0;

    dump_sequencer #(.UART_BUS_SIZE(UB), .NUM_REGS(NR), .REG_WIDTH(RW), .FRAME_SIZE(FS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_is_mem(i_is_mem), .i_delta(i_delta), .i_reg_bank(i_reg_bank),
        .i_clk_cycle(i_clk_cycle), .i_current_pc(i_current_pc),
        .i_write_finish(i_write_finish), .o_write(o_write), .o_data_write(o_data_write),
        .o_busy(o_busy), .o_finish(o_finish)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            i_reg_bank[k*RW +: RW] = bank[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frames of one dump, from bank/PC/cycle held constant over the dump.
    function automatic int build_exp(input bit delta, output int skip0);
        int  n = 0;
        bit  first = 1'b1;
        bit  eff = delta & DELTA_EN;
        logic [UB-1:0] ty = i_is_mem ? 8'h02 : 8'h01;
        skip0 = 0;
        for (int k = 0; k < NR; k++) begin
            if (eff && bank[k] == m_shadow[k]) begin
                if (first) skip0++;
            end else begin
                exp_q.push_back({ty, i_clk_cycle, UB'(k), bank[k]});
                n++;
                first = 1'b0;
            end
        end
        if (first) skip0 = NR;
        exp_q.push_back({8'h03, i_clk_cycle, 8'h00, i_current_pc});
        exp_q.push_back({8'h04, i_clk_cycle, 8'h00, RW'(n)});
        return n + 2;
    endfunction

    task automatic reset_model();
        exp_q.delete();
        have_frame = 1'b0;
        prev_write = 1'b0;
        for (int k = 0; k < NR; k++) m_shadow[k] = '0;
    endtask

    // Scoreboard: every emitted frame must be the next expected one; data holds between frames.
    always @(negedge i_clk) begin
        logic [FS-1:0] e;
        if (i_reset_n) begin
            if (o_write) begin
                chk("write_single_pulse", prev_write, 1'b0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", o_data_write, '0);
                    if (o_data_write == '0) chk("unexpected_frame", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", o_data_write, e);
                    if (e[FS-1 -: UB] == 8'h01 || e[FS-1 -: UB] == 8'h02)
                        m_shadow[e[RW +: UB]] = e[RW-1:0];
                end
                obs_q.push_back(o_data_write);
                last_frame = o_data_write;
                have_frame = 1'b1;
            end else if (have_frame) begin
                chk("frame_stable", o_data_write, last_frame);
            end
            if (o_finish) fin_cnt++;
            prev_write = o_write;
        end
    end

    // Runs one dump; 0 disables abort_at / busy_start_at / reset_at (1-based frame numbers).
    task automatic run_dump(input bit delta, input int ack_d, input int abort_at,
                            input int busy_start_at, input int reset_at);
        int n_exp, skip0, fin0, seen, budget, lat;
        @(negedge i_clk);
        obs_q.delete();
        n_exp = build_exp(delta, skip0);
        fin0 = fin_cnt;
        i_start = 1'b1;
        i_delta = delta;
        @(negedge i_clk);
        i_start = 1'b0;
        i_delta = 1'($urandom_range(0, 1));
        lat = 1;
        chk("busy_after_start", o_busy, 1'b1);
        seen = 0;
        while (seen < n_exp) begin
            budget = 0;
            while (!o_write && budget < 200) begin
                @(negedge i_clk);
                budget++;
                lat++;
            end
            if (!o_write) begin
                chk("frame_timeout", 1'b0, 1'b1);
                exp_q.delete();
                return;
            end
            if (seen == 0) begin
                last_lat = lat;
                chk("first_frame_latency", lat, 2 + skip0);
            end
            seen++;
            if (seen == abort_at) begin
                i_abort = 1'b1;
                i_write_finish = 1'b1;
                @(negedge i_clk);
                i_abort = 1'b0;
                i_write_finish = 1'b0;
                chk("abort_idle", o_busy, 1'b0);
                chk("abort_no_write", o_write, 1'b0);
                exp_q.delete();
                repeat (20) @(negedge i_clk);
                chk("abort_no_finish", fin_cnt, fin0);
                return;
            end
            if (seen == reset_at) begin
                i_reset_n = 1'b0;
                i_start = 1'b1;
                @(negedge i_clk);
                chk("rst_write", o_write, 1'b0);
                chk("rst_busy", o_busy, 1'b0);
                chk("rst_finish", o_finish, 1'b0);
                chk("rst_data", o_data_write, '0);
                reset_model();
                i_start = 1'b0;
                i_reset_n = 1'b1;
                repeat (10) @(negedge i_clk);
                chk("rst_stays_idle", o_busy, 1'b0);
                return;
            end
            if (seen == busy_start_at) i_start = 1'b1;
            repeat (ack_d) @(negedge i_clk);
            i_write_finish = 1'b1;
            @(negedge i_clk);
            i_write_finish = 1'b0;
            i_start = 1'b0;
        end
        chk("finish_pulse", o_finish, 1'b1);
        @(negedge i_clk);
        chk("idle_after_finish", o_busy, 1'b0);
        chk("finish_count", fin_cnt, fin0 + 1);
        chk("all_frames_seen", exp_q.size(), 0);
    endtask

    initial begin
        logic [FS-1:0] lit;
        for (int k = 0; k < NR; k++) bank[k] = '0;
        reset_model();

        repeat (3) @(negedge i_clk);
        chk("reset_write", o_write, 1'b0);
        chk("reset_busy", o_busy, 1'b0);
        chk("reset_finish", o_finish, 1'b0);
        chk("reset_data", o_data_write, '0);
        i_reset_n = 1'b1;

        // Delta dump after reset with only r3 non-zero.
        bank[3] = 32'd5;
        i_clk_cycle = 8'h11;
        i_current_pc = 32'h40;
        run_dump(1'b1, 1, 0, 0, 0);
`ifdef DUMP_DELTA_EN
        chk("delta_count", obs_q.size(), 3);
        lit = {8'h01, 8'h11, 8'h03, 32'd5};
        chk("delta_first_frame", obs_q[0], lit);
        lit = {8'h04, 8'h11, 8'h00, 32'd1};
        chk("delta_end_frame", obs_q[2], lit);
        chk("delta_latency", last_lat, 5);
`else
        chk("delta_ignored_count", obs_q.size(), 34);
        lit = {8'h01, 8'h11, 8'h00, 32'd0};
        chk("delta_ignored_first", obs_q[0], lit);
        chk("delta_ignored_latency", last_lat, 2);
`endif
        // Second delta dump without changes.
        run_dump(1'b1, 1, 0, 0, 0);
`ifdef DUMP_DELTA_EN
        chk("nochange_count", obs_q.size(), 2);
        lit = {8'h04, 8'h11, 8'h00, 32'd0};
        chk("nochange_end", obs_q[1], lit);
        chk("nochange_latency", last_lat, 34);
`else
        chk("nochange_full_count", obs_q.size(), 34);
`endif

        // Full dump r_k = k+0x100.
        for (int k = 0; k < NR; k++) bank[k] = 32'h100 + RW'(k);
        i_clk_cycle = 8'h22;
        run_dump(1'b0, 1, 0, 0, 0);
        chk("full_count", obs_q.size(), 34);
        lit = {8'h01, 8'h22, 8'h00, 32'h100};
        chk("full_r0", obs_q[0], lit);
        lit = {8'h01, 8'h22, 8'd31, 32'h11f};
        chk("full_r31", obs_q[31], lit);
        lit = {8'h03, 8'h22, 8'h00, 32'h40};
        chk("full_pc", obs_q[32], lit);
        lit = {8'h04, 8'h22, 8'h00, 32'd32};
        chk("full_end", obs_q[33], lit);
        chk("full_latency", last_lat, 2);

        // Backpressure, memory frames.
        i_is_mem = 1'b1;
        for (int k = 0; k < NR; k++) bank[k] = $urandom;
        run_dump(1'b0, 10, 0, 0, 0);
        chk("bp_count", obs_q.size(), 34);
        i_is_mem = 1'b0;

        // Abort during WAIT of register 7, then restart from register 0.
        for (int k = 0; k < NR; k++) bank[k] = $urandom;
        run_dump(1'b0, 2, 8, 0, 0);
        chk("abort_frames", obs_q.size(), 8);
        run_dump(1'b0, 0, 0, 0, 0);
        lit = {8'h01, i_clk_cycle, 8'h00, bank[0]};
        chk("restart_r0", obs_q[0], lit);

        // Start while busy is ignored.
        run_dump(1'b0, 1, 0, 4, 0);
        repeat (5) @(negedge i_clk);
        chk("no_second_dump", o_busy, 1'b0);

        // Reset mid-dump with start asserted.
        run_dump(1'b0, 1, 0, 0, 5);

        // Randomised dumps.
        for (int t = 0; t < 10; t++) begin
            for (int k = 0; k < NR; k++)
                if ($urandom_range(0, 3) == 0) bank[k] = $urandom;
            i_clk_cycle = UB'($urandom);
            i_current_pc = $urandom;
            i_is_mem = 1'($urandom_range(0, 1));
            run_dump(1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0, 0);
        end

        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dump_sequencer.md
# dump_sequencer

Parametrised debug-dump engine that serialises the register-bank snapshot, the current PC and an end-of-dump marker into fixed-width frames for the debug UART transmitter. It sits between the pipeline's debug taps and the UART frame writer. It generalises the register/memory printer with:
- configurable register count and width;
- an optional changed-only (delta) dump mode that uses a shadow copy of the last dumped values;
- an abort input and a terminating END frame carrying the frame count.

## Interface
Parameters:
- `UART_BUS_SIZE`, 8, width of the header, cycle and index fields.
- `NUM_REGS`, 32, registers in the bank. Must satisfy NUM_REGS ≤ 2^UART_BUS_SIZE.
- `REG_WIDTH`, 32, bits per register and of the PC.
- `FRAME_SIZE`, 3*UART_BUS_SIZE + REG_WIDTH, output frame width.

Ports:
- `i_clk` in 1: clock. Single clock domain; all ports are synchronous to it.
- `i_reset_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: begin a dump. Honoured only in IDLE.
- `i_abort` in 1: cancel an in-progress dump.
- `i_is_mem` in 1: type of register frames. 1 = memory (0x02), 0 = register (0x01).
- `i_delta` in 1: select changed-only mode. Sampled on the accepted `i_start`.
- `i_reg_bank` in NUM_REGS*REG_WIDTH: flat bank. Register k is at [k*REG_WIDTH +: REG_WIDTH].
- `i_clk_cycle` in UART_BUS_SIZE: cycle stamp.
- `i_current_pc` in REG_WIDTH: program counter.
- `i_write_finish` in 1: the UART writer has consumed the frame.
- `o_write` out 1: single-cycle frame-valid pulse.
- `o_data_write` out FRAME_SIZE: frame.
- `o_busy` out 1: high in every state except IDLE.
- `o_finish` out 1: single-cycle pulse when a dump completes.

## Operation
- Frame layout, MSB to LSB: {type, cycle, index, payload}.
  - Register frame: type 0x01 or 0x02, index = k zero-extended, payload = register k.
  - PC frame: type 0x03, index 0, payload = PC.
  - END frame: type 0x04, index 0, payload = count of register frames emitted in this dump, zero-extended.
- Pointer width: $clog2(NUM_REGS)+1. Sent-frame counter width: REG_WIDTH.
- States:
  - IDLE: on `i_start`, latch `i_delta`, clear the pointer and counter, go to SCAN.
  - SCAN, pointer < NUM_REGS:
    - If delta mode is latched and register k equals shadow k: skip. Pointer+1, stay in SCAN; one cycle per skipped register.
    - Otherwise: register the frame, write register k into shadow k, counter+1, pointer+1, set `o_write`, go to WAIT.
  - SCAN, pointer == NUM_REGS: emit the PC frame, pointer+1, go to WAIT.
  - SCAN, pointer == NUM_REGS+1: emit the END frame, pointer+1, go to WAIT.
  - SCAN, pointer > NUM_REGS+1: pulse `o_finish`, go to IDLE.
  - WAIT: `o_write` is deasserted after its first cycle. On `i_write_finish`, return to SCAN.
- The shadow is updated in full mode as well, so a delta dump following a full dump reports only changes since that full dump.
- `i_abort` in any non-IDLE state: next state is IDLE, `o_write` 0, no `o_finish`, pointer cleared. Shadow entries already written are kept.
- `i_abort` has priority over `i_write_finish` when both are asserted.
- `i_start` while busy is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `o_write`, `o_busy`, `o_finish` all 0;
  - `o_data_write` 0;
  - shadow all 0;
  - pointer and counter 0.
- Reset mid-dump: immediate return to these values on the next edge.
- Latency:
  - `i_start` at edge N: SCAN at N+1.
  - First frame: `o_write` high during cycle N+2 (full mode), or N+2+s with s skipped registers.
- `o_data_write` is held stable from the `o_write` pulse until the next frame is registered.
- `i_write_finish` is accepted in any WAIT cycle, including the cycle in which `o_write` is high.
- Each `i_write_finish` returns to SCAN one cycle later. Minimum frame spacing is 2 cycles.
- `o_finish` fires exactly one cycle after the END frame is acknowledged. IDLE follows on the next edge.
- `i_reg_bank`, `i_clk_cycle` and `i_current_pc` are sampled in the SCAN cycle that builds the frame, not at `i_start`.

## Configuration
- `DUMP_DELTA_EN` defined:
  - shadow bank (NUM_REGS*REG_WIDTH flops) and comparator are present;
  - `i_delta` behaves as specified above.
- `DUMP_DELTA_EN` undefined:
  - no shadow storage;
  - `i_delta` is ignored and every dump is a full dump;
  - all other behaviour and frame formats are identical.

## Test plan
- Full dump, `i_is_mem`=0, r_k = k+0x100, PC=0x40, writer acknowledges 1 cycle after each `o_write`:
  - 34 frames: 32 register frames 0x01/k/0x100+k, then PC 0x03/0/0x40, then END 0x04/0/32;
  - then one `o_finish` pulse.
- After reset, delta dump with only r3=5 (all other registers 0):
  - frames 0x01/3/5, PC, END payload 1.
  - A second delta dump with no changes gives PC and END payload 0 only.
- Backpressure: `i_write_finish` delayed 10 cycles per frame.
  - `o_write` pulses exactly once per frame.
  - `o_data_write` is stable throughout each wait.
  - No frame is lost or duplicated.
- `i_abort` asserted during WAIT of register 7:
  - IDLE next cycle, no further `o_write`, no `o_finish`.
  - A subsequent `i_start` restarts from register 0.
- `i_reset_n` low mid-dump and `i_start` asserted while busy:
  - all outputs return to their reset values;
  - the busy-time `i_start` produces no second dump.
- `DUMP_DELTA_EN` undefined, `i_delta`=1: a full 34-frame dump results.
